mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access unit that executes the load/store requests raised by the main controller's `MemRead`/`MemWrite` decode. It sits between the execute stage and a synchronous BRAM. Each request is turned into word-addressed RAM strobes with per-byte write enables and store-data lane replication. Loads return byte/half/word data sign- or zero-extended per `funct3`, and the core is stalled while BRAM read latency elapses.

## Interface
- `ADDR_WIDTH`, 14, BRAM word-address width; byte address bits `[ADDR_WIDTH+1:2]` are used.
- `RD_LATENCY`, 1, BRAM read latency in cycles; legal range 1–3.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `mem_read` input 1: load request from controller.
- `mem_write` input 1: store request from controller.
- `funct3` input 3: load/store width and sign field.
- `addr` input 32: byte address (ALU result).
- `wdata` input 32: store data (rs2).
- `stall` output 1: hold PC/pipeline; combinational.
- `rdata` output 32: extended load result, valid when load completes.
- `misalign` output 1: misaligned access flag; combinational.
- `bad_addr` output 32: last misaligned address.
- `ram_en` output 1: BRAM enable.
- `ram_we` output 4: BRAM byte write enables.
- `ram_addr` output ADDR_WIDTH: BRAM word address.
- `ram_wdata` output 32: lane-replicated store data.
- `ram_rdata` input 32: BRAM read data, valid RD_LATENCY cycles after `ram_en` with `ram_we`=0.

## Operation
- FSM states: IDLE, WAIT, DONE.
- Reset state is IDLE. On reset, `rdata`=0 and `bad_addr`=0.
- While `rst_n`=0, `stall`, `ram_en` and `ram_we` are forced to 0.
- IDLE, accepted load:
  - `ram_en`=1, `ram_we`=0, `stall`=1.
  - Latch `funct3` and `addr[1:0]`; load counter with RD_LATENCY−1.
  - Next state is WAIT, or DONE if RD_LATENCY=1.
- WAIT: `stall`=1; decrement counter; at 0, go to DONE.
- Data capture: on the edge RD_LATENCY cycles after issue, `ram_rdata` is extracted into `rdata`.
- DONE: `stall`=0 and `rdata` is valid. The core advances this cycle. No new request is sampled in DONE; next state is IDLE.
- IDLE, store:
  - Single cycle, no stall: `ram_en`=1 with `ram_we` and `ram_wdata` driven combinationally.
  - `sb` (000): `ram_we`=1<<addr[1:0]; data byte replicated ×4.
  - `sh` (001): `ram_we`=addr[1] ? 1100 : 0011; halfword replicated ×2.
  - `sw` (010) and any other funct3: `ram_we`=1111.
- Load extraction (funct3):
  - 000 `lb`: sign-extend byte at lane addr[1:0].
  - 100 `lbu`: zero-extend byte at lane addr[1:0].
  - 001 `lh`: sign-extend half at lane addr[1].
  - 101 `lhu`: zero-extend half at lane addr[1].
  - 010, 011, 110, 111: treated as `lw`.
- `ram_addr` = `addr[ADDR_WIDTH+1:2]`; upper bits are ignored (wrap-around).
- `mem_read` and `mem_write` both high: treated as a load, write suppressed.
- `rdata` holds its value until the next load completes.

## Timing
- Load latency: issue cycle plus RD_LATENCY cycles. `stall` is high for exactly RD_LATENCY cycles.
- Back-to-back loads cost RD_LATENCY+1 cycles each.
- A store immediately following a load is accepted in the IDLE cycle after DONE.
- Stores take 0 extra cycles.
- Async reset mid-load: the FSM returns to IDLE immediately and the pending load is discarded.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned = half access with addr[0]=1, or word access with addr[1:0]≠00.
  - A misaligned access in IDLE drives `misalign`=1 and suppresses `ram_en`, `ram_we` and `stall`.
  - `bad_addr` latches `addr` on that edge.
  - A misaligned load completes nothing; `rdata` is unchanged.
- `MISALIGN_TRAP_EN` undefined:
  - Low address bits are forced aligned (half: addr[0]→0; word: addr[1:0]→00).
  - `misalign`=0 and `bad_addr`=0 permanently.

## Test plan
- Store word, then load word: `sw` of 0xDEADBEEF at 0x100, then `lw` at 0x100 with RD_LATENCY=1 → `ram_we`=1111, `ram_addr`=0x40; `stall` high 1 cycle; `rdata`=0xDEADBEEF in DONE.
- Byte loads: word 0x80FF7F01 at 0x20; `lb` at 0x23 → 0xFFFFFF80; `lbu` at 0x23 → 0x00000080; `lb` at 0x21 → 0x0000007F.
- Store/load halfword: `sh` 0x0000ABCD at 0x12 → `ram_we`=1100, `ram_wdata`=0xABCDABCD; then `lh` at 0x12 → 0xFFFFABCD; `lhu` → 0x0000ABCD.
- Misaligned word load with macro: `lw` at 0x101 → `misalign`=1, `ram_en`=0, `stall`=0, `bad_addr`=0x101 next cycle. Without macro: the access goes to 0x100 and `misalign`=0.
- Reset during load: RD_LATENCY=3, assert `rst_n`=0 in WAIT → `stall`=0 and `rdata`=0 at once. After release, the FSM is in IDLE and a new `lw` completes normally.
- Simultaneous request: `mem_read`=`mem_write`=1 at 0x40 → `ram_we`=0000, load performed, memory contents unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: executes controller load/store requests against a
// synchronous BRAM. Stores complete in the request cycle. Loads stall the core
// until the BRAM read latency has elapsed, then return byte/half/word data that
// has been sign- or zero-extended.
//
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned accesses.
// When it is defined, a misaligned access is dropped and its address is kept
// in bad_addr. When it is undefined, the low address bits are treated as
// aligned.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   mem_read        load request
//   mem_write       store request
//   funct3          access width and sign field
//   addr            byte address
//   wdata           store data
//   stall           holds the core while a load is in flight (combinational)
//   rdata           extended load result, valid from DONE onward
//   misalign        misaligned-access flag (combinational)
//   bad_addr        address of the last misaligned access
//   ram_en          BRAM enable
//   ram_we          BRAM byte write enables
//   ram_addr        BRAM word address
//   ram_wdata       store data replicated across byte lanes
//   ram_rdata       BRAM read data, RD_LATENCY cycles after a read enable
module mem_access_unit #(
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  misalign,
    output logic [31:0]           bad_addr,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic [31:0] ld_val;
    logic [3:0]  st_we;
    logic        st_byte, st_half;
    logic        issue;

    // Address bits above the BRAM word range are ignored, so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    assign ram_addr = addr[ADDR_WIDTH+1:2];

    // Store classification: only 000 and 001 are narrow. Every other
    // funct3 value writes a full word.
    assign st_byte = (funct3 == 3'b000);
    assign st_half = (funct3 == 3'b001);

    always_comb begin
        st_we     = 4'b1111;
        ram_wdata = wdata;
        if (st_byte) begin
            st_we     = 4'b0001 << addr[1:0];
            ram_wdata = {4{wdata[7:0]}};
        end else if (st_half) begin
            st_we     = addr[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{wdata[15:0]}};
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic        acc_half, acc_word, mis_raw;
    logic [31:0] bad_addr_q;

    // Loads decode width from funct3[1:0]. Stores use the full funct3 value.
    assign acc_half = mem_read ? (funct3[1:0] == 2'b01) : st_half;
    assign acc_word = mem_read ? funct3[1] : !(st_byte || st_half);
    assign mis_raw  = (acc_half && addr[0]) || (acc_word && (addr[1:0] != 2'b00));
    assign misalign = (state_q == IDLE) && (mem_read || mem_write) && mis_raw;
    assign bad_addr = bad_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        bad_addr_q <= '0;
        else if (misalign) bad_addr_q <= addr;
    end
`else
    assign misalign = 1'b0;
    assign bad_addr = '0;
`endif

    assign issue = (state_q == IDLE) && mem_read && !misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        ram_en  = 1'b0;
        ram_we  = 4'b0000;
        case (state_q)
            IDLE: begin
                if (!misalign) begin
                    if (mem_read) begin
                        // A read takes priority over a simultaneous write,
                        // so the write is suppressed.
                        ram_en  = 1'b1;
                        stall   = 1'b1;
                        cnt_d   = 2'(RD_LATENCY - 1);
                        state_d = (RD_LATENCY == 1) ? DONE : WAIT;
                    end else if (mem_write) begin
                        ram_en = 1'b1;
                        ram_we = st_we;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            stall  = 1'b0;
            ram_en = 1'b0;
            ram_we = 4'b0000;
        end
    end

    // BRAM data is valid during DONE. rdata passes it straight through in
    // that cycle and captures it at the end of DONE, so the value stays
    // visible until the next load completes.
    always_comb begin
        ld_val = ram_rdata;
        case (f3_q[1:0])
            2'b00: begin
                ld_val = {24'd0, ram_rdata[8*off_q +: 8]};
                if (!f3_q[2]) ld_val[31:8] = {24{ld_val[7]}};
            end
            2'b01: begin
                ld_val = {16'd0, ram_rdata[16*off_q[1] +: 16]};
                if (!f3_q[2]) ld_val[31:16] = {16{ld_val[15]}};
            end
            default: ld_val = ram_rdata;
        endcase
    end

    assign rdata = (state_q == DONE) ? ld_val : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                f3_q  <= funct3;
                off_q <= addr[1:0];
            end
            if (state_q == DONE) rdata_q <= ld_val;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic init_mem;
    always #5 clk = ~clk;

    logic        mr [2];
    logic        mw [2];
    logic [2:0]  f3 [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        st [2];
    logic [31:0] rd [2];
    logic        mis [2];
    logic [31:0] ba [2];
    logic        en [2];
    logic [3:0]  we [2];
    logic [AW-1:0] ra [2];
    logic [31:0] rwd [2];
    logic [31:0] rrd [2];

    // Instance 0 uses RD_LATENCY=1. Instance 1 uses RD_LATENCY=3. Each has its own BRAM model.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        mem_access_unit #(.ADDR_WIDTH(AW), .RD_LATENCY(L)) u_dut (
            .clk(clk), .rst_n(rst_n), .mem_read(mr[g]), .mem_write(mw[g]),
            .funct3(f3[g]), .addr(ad[g]), .wdata(wd[g]), .stall(st[g]),
            .rdata(rd[g]), .misalign(mis[g]), .bad_addr(ba[g]), .ram_en(en[g]),
            .ram_we(we[g]), .ram_addr(ra[g]), .ram_wdata(rwd[g]), .ram_rdata(rrd[g])
        );
        logic [31:0] mem [256];
        logic [31:0] pipe [3];
        always @(posedge clk) begin
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            if (init_mem) begin
                for (int i = 0; i < 256; i++) mem[i] <= '0;
            end else if (en[g]) begin
                if (we[g] == 4'b0000) pipe[0] <= mem[ra[g]];
                for (int b = 0; b < 4; b++)
                    if (we[g][b]) mem[ra[g]][8*b +: 8] <= rwd[g][8*b +: 8];
            end
        end
        assign rrd[g] = pipe[L-1];
    end

    logic [31:0] ref_mem [2][256];
    logic [31:0] last_rd [2];
    int total = 0, passed = 0, fails = 0;

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic mis_exp(bit ld, logic [2:0] f, logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        bit half, byt;
        half = ld ? (f[1:0] == 2'd1) : (f == 3'd1);
        byt  = ld ? (f[1:0] == 2'd0) : (f == 3'd0);
        return (half && a[0]) || (!half && !byt && (a % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    // Reference load result, built from byte-addressed arithmetic on the model memory.
    function automatic logic [31:0] ld_exp(int d, logic [2:0] f, logic [31:0] a);
        logic [31:0] w, v;
        w = ref_mem[d][(a >> 2) & 255];
        if (f[1:0] == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!f[2] && v >= 128) v = v - 256;
        end else if (f[1:0] == 2'd1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!f[2] && v >= 32768) v = v - 65536;
        end else v = w;
        return v;
    endfunction

    task automatic do_store(int d, logic [2:0] f, logic [31:0] a, logic [31:0] w);
        logic [3:0] ew;
        logic [31:0] rep;
        logic [31:0] idx;
        idx = (a >> 2) & 255;
        if (f == 3'd0) begin
            ew = 4'b0001 << (a % 4);
            rep = (w & 32'hFF) * 32'h01010101;
        end else if (f == 3'd1) begin
            ew = a[1] ? 4'hC : 4'h3;
            rep = (w & 32'hFFFF) * 32'h00010001;
        end else begin
            ew = 4'hF;
            rep = w;
        end
        mw[d] = 1'b1; f3[d] = f; ad[d] = a; wd[d] = w;
        #1;
        if (mis_exp(0, f, a)) begin
            chk("st_misalign", 32'(mis[d]), 1);
            chk("st_mis_en", 32'(en[d]), 0);
            chk("st_mis_we", 32'(we[d]), 0);
            tick();
            mw[d] = 1'b0;
            chk("st_bad_addr", ba[d], a);
        end else begin
            chk("st_en", 32'(en[d]), 1);
            chk("st_we", 32'(we[d]), 32'(ew));
            chk("st_stall", 32'(st[d]), 0);
            chk("st_wdata", rwd[d], rep);
            chk("st_addr", 32'(ra[d]), idx);
            chk("st_misalign", 32'(mis[d]), 0);
            for (int b = 0; b < 4; b++)
                if (ew[b]) ref_mem[d][idx][8*b +: 8] = rep[8*b +: 8];
            tick();
            mw[d] = 1'b0;
        end
    endtask

    task automatic do_load(int d, logic [2:0] f, logic [31:0] a, bit both, logic [31:0] w);
        logic [31:0] exp;
        int cyc;
        exp = ld_exp(d, f, a);
        mr[d] = 1'b1; mw[d] = both; f3[d] = f; ad[d] = a; wd[d] = w;
        #1;
        if (mis_exp(1, f, a)) begin
            chk("ld_misalign", 32'(mis[d]), 1);
            chk("ld_mis_en", 32'(en[d]), 0);
            chk("ld_mis_stall", 32'(st[d]), 0);
            tick();
            mr[d] = 1'b0; mw[d] = 1'b0;
            chk("ld_bad_addr", ba[d], a);
            chk("ld_mis_rdata", rd[d], last_rd[d]);
            tick();
            return;
        end
        chk("ld_en", 32'(en[d]), 1);
        chk("ld_we", 32'(we[d]), 0);
        chk("ld_addr", 32'(ra[d]), (a >> 2) & 255);
        chk("ld_misalign", 32'(mis[d]), 0);
`ifndef MISALIGN_TRAP_EN
        chk("bad_addr_zero", ba[d], 0);
`endif
        cyc = 0;
        while (st[d] === 1'b1 && cyc < 8) begin
            cyc++;
            tick();
        end
        chk("stall_cycles", 32'(cyc), 32'(lat(d)));
        chk("ld_rdata", rd[d], exp);
        mr[d] = 1'b0; mw[d] = 1'b0;
        tick();
        chk("ld_rdata_hold", rd[d], exp);
        last_rd[d] = exp;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mr[d] = 0; mw[d] = 0; f3[d] = 0; ad[d] = 0; wd[d] = 0; last_rd[d] = 0;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = 0;
        end
        rst_n = 1'b0;
        init_mem = 1'b1;
        mr[0] = 1'b1;   // Hold a request during reset. It must have no effect.
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_stall", 32'(st[d]), 0);
            chk("rst_en", 32'(en[d]), 0);
            chk("rst_we", 32'(we[d]), 0);
            chk("rst_rdata", rd[d], 0);
            chk("rst_bad_addr", ba[d], 0);
        end
        mr[0] = 1'b0;
        init_mem = 1'b0;
        rst_n = 1'b1;
        tick();

        for (int d = 0; d < 2; d++) begin
            do_store(d, 3'b010, 32'h100, 32'hDEADBEEF);
            do_load(d, 3'b010, 32'h100, 0, 0);
            do_store(d, 3'b010, 32'h20, 32'h80FF7F01);
            do_load(d, 3'b000, 32'h23, 0, 0);
            do_load(d, 3'b100, 32'h23, 0, 0);
            do_load(d, 3'b000, 32'h21, 0, 0);
            do_store(d, 3'b001, 32'h12, 32'h0000ABCD);
            do_load(d, 3'b001, 32'h12, 0, 0);
            do_load(d, 3'b101, 32'h12, 0, 0);
            do_load(d, 3'b010, 32'h101, 0, 0);
            do_store(d, 3'b010, 32'h40, 32'h12345678);
            do_load(d, 3'b010, 32'h40, 1, 32'hCAFEF00D);
            do_load(d, 3'b010, 32'h40, 0, 0);
            do_store(d, 3'b000, 32'h7FD, 32'h000000A5);   // wraps to word 0xFF
            do_load(d, 3'b100, 32'h3FD, 0, 0);
        end

        for (int i = 0; i < 80; i++) begin
            int d, op;
            logic [2:0] f;
            logic [31:0] a, w;
            d  = i % 2;
            op = $urandom_range(0, 2);
            f  = 3'($urandom_range(0, 7));
            a  = (i % 3 == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 63);
            w  = $urandom;
            if (op == 0) do_store(d, f, a, w);
            else do_load(d, f, a, op == 2, w);
        end

        // Asynchronous reset while the latency-3 instance is in WAIT.
        mr[1] = 1'b1; mw[1] = 1'b0; f3[1] = 3'b010; ad[1] = 32'h100;
        tick();
        chk("wait_stall", 32'(st[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(st[1]), 0);
        chk("rst_mid_rdata", rd[1], 0);
        chk("rst_mid_en", 32'(en[1]), 0);
        mr[1] = 1'b0;
        last_rd[0] = 0; last_rd[1] = 0;
        tick();
        rst_n = 1'b1;
        tick();
        do_load(1, 3'b010, 32'h100, 0, 0);
        do_load(0, 3'b010, 32'h100, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
